// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the programmable serial pattern detector:
//   clog2         - constant function used to size the window fill counter
//   SEQ_PAT_1011  - default pattern loaded at reset
//   MODE_NONOVL / MODE_OVL - encodings of the overlap input
// ---------------------------------------------------------------------------
package seq_det_pkg;

    localparam logic [3:0] SEQ_PAT_1011 = 4'b1011;

    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset, clears count
//   inc    - add one this cycle (held at the maximum once reached)
//   clr    - synchronous clear; clear together with inc yields 1
//   count  - current value, CNT_W bits
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            // A match landing on the clear cycle is not lost.
            count <= inc ? CNT_ONE : '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
// Runtime-programmable serial bit-pattern detector with care mask,
// selectable overlapping / non-overlapping detection, input qualification
// and a saturating match counter.
//   clock        - rising-edge clock
//   reset        - asynchronous active-low reset
//   sequence_in  - serial data bit, sampled only when in_valid is high
//   in_valid     - qualifies sequence_in
//   overlap      - 1: overlapping detection, 0: non-overlapping
//   pat_load     - load pat_value / pat_mask and restart the window
//   pat_value    - new pattern, MSB is the oldest bit
//   pat_mask     - care mask, 1 = compare bit, 0 = don't care
//   count_clr    - synchronous clear of match_count
//   detector_out - registered one-cycle match pulse
//   match_count  - saturating number of matches
//   armed        - a full window of history is held
// ---------------------------------------------------------------------------
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W     = 4,
    parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(SEQ_PAT_1011),
    parameter int               CNT_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sequence_in,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_value,
    input  logic [PAT_W-1:0] pat_mask,
    input  logic             count_clr,
    output logic             detector_out,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int               FILL_W    = clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

    logic [PAT_W-1:0]  history_q;
    logic [PAT_W-1:0]  history_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic [FILL_W-1:0] fill_inc;
    logic [PAT_W-1:0]  pattern_q;
    logic [PAT_W-1:0]  mask_q;
    logic [PAT_W-1:0]  win;
    logic              hit;
    logic              match;
    logic              match_p1;
    logic              armed_p1;

    // Candidate window and match evaluation for the bit presented this cycle.
    always_comb begin
        win       = {history_q[PAT_W-2:0], sequence_in};
        fill_inc  = (fill_q == FILL_FULL) ? FILL_FULL : (fill_q + FILL_ONE);
        hit       = (((win ^ pattern_q) & mask_q) == '0);
        // A load restarts the window, so a bit arriving with it is dropped.
        match     = in_valid && !pat_load && (fill_inc == FILL_FULL) && hit;

        history_d = history_q;
        fill_d    = fill_q;
        if (pat_load) begin
            history_d = '0;
            fill_d    = '0;
        end else if (in_valid) begin
            if (match && (overlap == MODE_NONOVL)) begin
                // Non-overlapping: the matched bits cannot be reused.
                history_d = '0;
                fill_d    = '0;
            end else begin
                history_d = win;
                fill_d    = fill_inc;
            end
        end
    end

    // ---- stage p1: registered window state and outputs ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            history_q <= '0;
            fill_q    <= '0;
            pattern_q <= PAT_RESET;
            mask_q    <= '1;
            match_p1  <= 1'b0;
            armed_p1  <= 1'b0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
            if (pat_load) begin
                pattern_q <= pat_value;
                mask_q    <= pat_mask;
            end
            match_p1  <= match;
            // Tracks fill_q == PAT_W, computed from the value being loaded.
            armed_p1  <= (fill_d == FILL_FULL);
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (match),
        .clr   (count_clr),
        .count (match_count)
    );

    assign detector_out = match_p1;
    assign armed        = armed_p1;

endmodule
